// File: rtl/memset_stream_pkg.sv
// Shared types, CSR field positions and the pattern replication helper for memset_stream.
package memset_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    ELEM_8      = 2'd0,
    ELEM_16     = 2'd1,
    ELEM_32     = 2'd2,
    ELEM_32_ALT = 2'd3
  } elem_size_e;

  typedef enum logic [1:0] {
    MODE_FILL     = 2'd0,
    MODE_REPLACE  = 2'd1,
    MODE_PASS     = 2'd2,
    MODE_FILL_ALT = 2'd3
  } mode_e;

  localparam int SIZE_LSB = 0;
  localparam int SIZE_MSB = 1;
  localparam int MODE_LSB = 4;
  localparam int MODE_MSB = 5;

  // Builds one 32-bit word of replicated elements; callers replicate the word across the beat.
  function automatic logic [31:0] replicate_pattern(input logic [31:0] value,
                                                    input elem_size_e elem_size);
    case (elem_size)
      ELEM_8:  return {4{value[7:0]}};
      ELEM_16: return {2{value[15:0]}};
      default: return value;
    endcase
  endfunction

endpackage

// File: rtl/memset_out_reg.sv
// One-entry valid/ready pipeline register: refills in the same cycle it drains, so 1 beat/cycle.
module memset_out_reg #(
  parameter int dataWidth = 512
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [dataWidth-1:0] in_bits,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [dataWidth-1:0] out_bits
);

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_bits  <= '0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_bits  <= in_bits;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/memset_stream.sv
// Memset streamer core: FILL / REPLACE / PASS of N beats with a replicated 8/16/32-bit pattern.
// Build option MEMSET_INCR_EN: pattern advances by csr3 after every generated beat.
// Handshake: a transfer happens on a rising edge where valid and ready are both high; valid never
// depends on ready, and once raised the output valid/bits hold until the transfer.
module memset_stream
  import memset_stream_pkg::*;
#(
  parameter int userCsrNum = 4,
  parameter int dataWidth  = 512
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 ext_data_i_ready,
  input  logic                 ext_data_i_valid,
  input  logic [dataWidth-1:0] ext_data_i_bits,
  input  logic                 ext_data_o_ready,
  output logic                 ext_data_o_valid,
  output logic [dataWidth-1:0] ext_data_o_bits,
  input  logic [31:0]          ext_csr_i_0,
  input  logic [31:0]          ext_csr_i_1,
  input  logic [31:0]          ext_csr_i_2,
  input  logic [31:0]          ext_csr_i_3,
  input  logic                 ext_start_i,
  output logic                 ext_busy_o,
  output logic [1:0]           dbg_state
);

  logic [userCsrNum*32-1:0] csr_bus;
  assign csr_bus = {ext_csr_i_3, ext_csr_i_2, ext_csr_i_1, ext_csr_i_0};

  logic [31:0] csr_cfg;
  logic [31:0] csr_count;
  assign csr_cfg   = csr_bus[63:32];
  assign csr_count = csr_bus[95:64];

  state_e      state_q, state_d;
  logic [31:0] remaining_q;
  logic [31:0] pattern_q;
  elem_size_e  size_q;
  mode_e       mode_q;

  logic start_ok, is_run, is_fill, is_pass, gen_ready, issue, out_valid;
  logic [dataWidth-1:0] beat;

  assign start_ok  = ext_start_i && (csr_count != 32'd0);
  assign is_run    = (state_q == RUN);
  assign is_fill   = (mode_q == MODE_FILL) || (mode_q == MODE_FILL_ALT);
  assign is_pass   = (mode_q == MODE_PASS);
  assign issue     = is_run && gen_ready && (is_fill || ext_data_i_valid);
  assign beat      = is_pass ? ext_data_i_bits
                             : {(dataWidth/32){replicate_pattern(pattern_q, size_q)}};

  assign ext_data_i_ready = is_run && !is_fill && gen_ready;
  assign ext_data_o_valid = out_valid;
  assign ext_busy_o       = (state_q != IDLE);
  assign dbg_state        = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = RUN;
      RUN:     if (issue && remaining_q == 32'd1) state_d = DRAIN;
      DRAIN:   if (out_valid && ext_data_o_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef MEMSET_INCR_EN
  logic [31:0] step_q;
  logic        unused_csr;
  assign unused_csr = ^{csr_cfg[31:6], csr_cfg[3:2]};
`else
  logic        unused_csr;
  assign unused_csr = ^{csr_bus[127:96], csr_cfg[31:6], csr_cfg[3:2]};
`endif

  // Operation parameters are captured only at an accepted start, so CSR writes while busy are inert.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining_q <= '0;
      pattern_q   <= '0;
      size_q      <= ELEM_8;
      mode_q      <= MODE_FILL;
`ifdef MEMSET_INCR_EN
      step_q      <= '0;
`endif
    end else if (state_q == IDLE && start_ok) begin
      remaining_q <= csr_count;
      pattern_q   <= csr_bus[31:0];
      size_q      <= elem_size_e'(csr_cfg[SIZE_MSB:SIZE_LSB]);
      mode_q      <= mode_e'(csr_cfg[MODE_MSB:MODE_LSB]);
`ifdef MEMSET_INCR_EN
      step_q      <= csr_bus[127:96];
`endif
    end else if (issue) begin
      remaining_q <= remaining_q - 32'd1;
`ifdef MEMSET_INCR_EN
      // Full 32-bit sum; only the low element-size bits reach the beat, giving modulo wrap.
      if (!is_pass) pattern_q <= pattern_q + step_q;
`endif
    end
  end

  memset_out_reg #(.dataWidth(dataWidth)) u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (issue),
    .in_ready  (gen_ready),
    .in_bits   (beat),
    .out_valid (out_valid),
    .out_ready (ext_data_o_ready),
    .out_bits  (ext_data_o_bits)
  );

endmodule

// File: tb/tb_memset_stream.sv
// Directed + randomized bench for memset_stream with a queue-based reference of expected beats.
module tb_memset_stream;

  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ext_data_i_ready;
  logic          ext_data_i_valid;
  logic [DW-1:0] ext_data_i_bits;
  logic          ext_data_o_ready;
  logic          ext_data_o_valid;
  logic [DW-1:0] ext_data_o_bits;
  logic [31:0]   ext_csr_i_0, ext_csr_i_1, ext_csr_i_2, ext_csr_i_3;
  logic          ext_start_i;
  logic          ext_busy_o;
  logic [1:0]    dbg_state;

  memset_stream #(.userCsrNum(4), .dataWidth(DW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ext_data_i_ready (ext_data_i_ready),
    .ext_data_i_valid (ext_data_i_valid),
    .ext_data_i_bits  (ext_data_i_bits),
    .ext_data_o_ready (ext_data_o_ready),
    .ext_data_o_valid (ext_data_o_valid),
    .ext_data_o_bits  (ext_data_o_bits),
    .ext_csr_i_0      (ext_csr_i_0),
    .ext_csr_i_1      (ext_csr_i_1),
    .ext_csr_i_2      (ext_csr_i_2),
    .ext_csr_i_3      (ext_csr_i_3),
    .ext_start_i      (ext_start_i),
    .ext_busy_o       (ext_busy_o),
    .dbg_state        (dbg_state)
  );

  // clock/reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] in_q[$];
  int            in_idx, cyc, out_cnt, in_cnt, first_hs, last_hs, drop_cyc;
  logic          busy_seen, iready_seen, prev_stall;
  logic [DW-1:0] prev_bits;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference beat: element value truncated to its size, replicated from the LSBs upward.
  function automatic logic [DW-1:0] pattern_beat(input logic [31:0] v, input int size);
    logic [DW-1:0] b;
    int ew;
    ew = (size == 0) ? 8 : (size == 1) ? 16 : 32;
    for (int i = 0; i < DW; i++) b[i] = v[i % ew];
    return b;
  endfunction

  function automatic logic [DW-1:0] rand_beat();
    logic [DW-1:0] b;
    for (int i = 0; i < DW/32; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  // One cycle: inputs were set at the negedge; observe the transfers the next posedge will make.
  task automatic tick();
    #1;
    if (ext_data_i_ready) iready_seen = 1'b1;
    if (ext_busy_o) busy_seen = 1'b1;
    if (prev_stall) begin
      check("hold_valid", ext_data_o_valid, 1);
      check("hold_bits", ext_data_o_bits, prev_bits);
    end
    if (ext_data_i_valid && ext_data_i_ready) begin
      in_cnt++;
      in_idx++;
    end
    if (ext_data_o_valid && ext_data_o_ready) begin
      if (exp_q.size() == 0) check("extra_beat", ext_data_o_valid, 0);
      else check("beat", ext_data_o_bits, exp_q.pop_front());
      if (out_cnt == 0) first_hs = cyc;
      last_hs = cyc;
      out_cnt++;
    end
    prev_stall = ext_data_o_valid && !ext_data_o_ready;
    prev_bits  = ext_data_o_bits;
    @(negedge clk);
    cyc++;
  endtask

  // rmode: 0 = output always ready, 1 = toggling, 2 = random. vprob: input valid percentage.
  task automatic run_op(input int mode, input int size, input logic [31:0] pat, input int n,
                        input int vprob, input int rmode, input int restart, input logic [31:0] step);
    logic is_fill;
    is_fill = (mode == 0) || (mode == 3);
    in_q.delete(); exp_q.delete();
    for (int k = 0; k < n + 4; k++) in_q.push_back(rand_beat());
    for (int k = 0; k < n; k++) begin
      if (mode == 2) exp_q.push_back(in_q[k]);
`ifdef MEMSET_INCR_EN
      else exp_q.push_back(pattern_beat(pat + step * k, size));
`else
      else exp_q.push_back(pattern_beat(pat, size));
`endif
    end
    in_idx = 0; in_cnt = 0; out_cnt = 0; first_hs = 0; last_hs = -1; drop_cyc = -100;
    busy_seen = 0; iready_seen = 0; prev_stall = 0;
    ext_csr_i_0 = pat;
    ext_csr_i_1 = ($urandom & 32'hFFFF_FFCC) | (mode << 4) | size;
    ext_csr_i_2 = n;
    ext_csr_i_3 = step;
    ext_start_i = 1'b1; ext_data_i_valid = 1'b0; ext_data_o_ready = 1'b1;
    tick();
    ext_start_i = 1'b0;
    check("busy_rise", ext_busy_o, (n != 0));
    for (int c = 0; c < 200; c++) begin
      ext_data_i_valid = ($urandom_range(99) < vprob);
      ext_data_i_bits  = in_q[in_idx];
      ext_data_o_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? (c % 2 == 0) : 1'($urandom_range(1));
      if (restart != 0 && c == 3) begin
        ext_start_i = 1'b1; ext_csr_i_2 = n + 3; ext_csr_i_0 = ~pat; ext_csr_i_1 ^= 32'h10;
      end else ext_start_i = 1'b0;
      tick();
      if (!ext_busy_o && (n != 0 || c >= 5)) begin
        drop_cyc = cyc;
        break;
      end
    end
    ext_start_i = 1'b0;
    check("op_done", ext_busy_o, 0);
    check("beat_count", out_cnt, n);
    check("exp_empty", exp_q.size(), 0);
    check("in_count", in_cnt, is_fill ? 0 : n);
    if (n != 0) check("busy_drop", drop_cyc, last_hs + 1);
    else check("busy_never", busy_seen, 0);
    if (is_fill) check("fill_no_iready", iready_seen, 0);
    if (is_fill && rmode == 0 && n != 0) check("fill_back_to_back", last_hs - first_hs, n - 1);
    // Input offered after completion must not be taken.
    iready_seen = 0;
    ext_data_i_valid = 1'b1; ext_data_i_bits = in_q[in_idx]; ext_data_o_ready = 1'b1;
    repeat (3) tick();
    check("no_extra_consume", iready_seen, 0);
    ext_data_i_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    ext_data_i_valid = 1'b0; ext_data_i_bits = '0; ext_data_o_ready = 1'b0;
    ext_csr_i_0 = '0; ext_csr_i_1 = '0; ext_csr_i_2 = '0; ext_csr_i_3 = '0; ext_start_i = 1'b0;
    cyc = 0; prev_stall = 0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_o_valid", ext_data_o_valid, 0);
    check("rst_o_bits", ext_data_o_bits, 0);
    check("rst_i_ready", ext_data_i_ready, 0);
    check("rst_busy", ext_busy_o, 0);
    check("rst_state", dbg_state, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(0, 0, 32'h0000_00A5, 4, 0, 0, 0, 32'h0);          // FILL 8b
    run_op(1, 1, 32'h0000_1234, 3, 50, 0, 0, 32'h0);         // REPLACE 16b, input stalls
    run_op(2, 0, 32'h0, 5, 100, 1, 0, 32'h0);                // PASS, toggling ready
    run_op(0, 2, 32'h0, 0, 100, 0, 0, 32'h0);                // N = 0
    run_op(0, 2, 32'hCAFE_F00D, 4, 0, 0, 1, 32'h0);          // restart while busy
    run_op(3, 3, 32'h1357_9BDF, 3, 0, 2, 0, 32'h0);          // FILL alias, 32b alias
`ifdef MEMSET_INCR_EN
    run_op(0, 0, 32'h0000_00FE, 3, 0, 0, 0, 32'h1);          // 8-bit wrap
    run_op(1, 1, 32'h0000_FFF0, 4, 70, 2, 0, 32'h0000_0008); // 16-bit wrap
`endif
    for (int t = 0; t < 4; t++)
      run_op($urandom_range(3), $urandom_range(3), $urandom, $urandom_range(1, 6), 60, 2, 0, $urandom);

    // Reset in the middle of an 8-beat fill.
    exp_q.delete(); in_q.delete();
    for (int k = 0; k < 8; k++) exp_q.push_back(pattern_beat(32'h3C, 0));
    out_cnt = 0; busy_seen = 0; prev_stall = 0; last_hs = -1;
    ext_csr_i_0 = 32'h3C; ext_csr_i_1 = 32'h0; ext_csr_i_2 = 8; ext_csr_i_3 = 32'h0;
    ext_start_i = 1'b1; ext_data_o_ready = 1'b1;
    tick();
    ext_start_i = 1'b0;
    for (int c = 0; c < 20 && out_cnt < 2; c++) tick();
    check("pre_reset_beats", out_cnt, 2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_o_valid", ext_data_o_valid, 0);
    check("mid_rst_busy", ext_busy_o, 0);
    check("mid_rst_bits", ext_data_o_bits, 0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete(); out_cnt = 0; busy_seen = 0; prev_stall = 0;
    repeat (10) tick();
    check("post_reset_beats", out_cnt, 0);
    check("post_reset_busy", busy_seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/memset_stream.md
Name: memset_stream

Overview:
- Second-generation memset streamer accelerator core: fills or rewrites a configurable number of dataWidth-bit beats with a replicated 8/16/32-bit pattern.
- Sits behind the cluster CSR/streamer wrapper: ext_data_i from the read streamer, ext_data_o to the write streamer.
- Adds over the previous core:
  - start/busy control FSM with a beat counter;
  - a generate-only fill mode;
  - element-size selection;
  - a registered output stage.

Parameters:
- userCsrNum, 4, number of 32-bit CSR inputs; fixed at 4 for this block.
- dataWidth, 512, stream beat width in bits; must be a multiple of 32.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- ext_data_i_ready  output  1  input stream ready.
- ext_data_i_valid  input  1  input stream valid.
- ext_data_i_bits  input  dataWidth  input beat.
- ext_data_o_ready  input  1  output stream ready.
- ext_data_o_valid  output  1  output stream valid.
- ext_data_o_bits  output  dataWidth  output beat.
- ext_csr_i_0  input  32  pattern value.
- ext_csr_i_1  input  32  [1:0] element size (0=8b, 1=16b, 2=32b, 3=32b); [5:4] mode (0=FILL, 1=REPLACE, 2=PASS, 3=FILL).
- ext_csr_i_2  input  32  beat count N.
- ext_csr_i_3  input  32  increment step; used only with MEMSET_INCR_EN.
- ext_start_i  input  1  single-cycle start pulse.
- ext_busy_o  output  1  high while an operation is in flight.

Behaviour:
- Reset (async, rst_n=0):
  - FSM to IDLE; counter and output register cleared.
  - ext_data_o_valid=0, ext_data_o_bits=0, ext_data_i_ready=0, ext_busy_o=0.
  - Reset mid-operation aborts immediately; no beat is emitted after deassertion until a new start.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE, ext_start_i=1 and N!=0: latch all CSRs, load remaining=N, go to RUN; ext_busy_o=1 from the next cycle.
  - IDLE, start with N=0: ignored; busy stays 0.
  - Start while not IDLE: ignored; CSR changes while busy have no effect.
  - RUN: each beat issued into the output register decrements remaining. When the last beat is issued, go to DRAIN.
  - DRAIN: when the output register empties (final output handshake), go to IDLE. ext_busy_o drops the cycle after the final ext_data_o handshake.
- Pattern:
  - 8b: csr0[7:0] replicated dataWidth/8 times.
  - 16b: csr0[15:0] replicated.
  - 32b: csr0 replicated.
  - Element 0 occupies the LSBs.
- Modes:
  - FILL: ext_data_i_ready=0 always. A beat is generated whenever the output register can accept one.
  - REPLACE: one input beat is consumed per output beat; its data is discarded and the pattern is emitted.
  - PASS: input data is forwarded unchanged, N beats.
- Output register (one entry):
  - Accepts a new beat when empty or when ext_data_o_ready=1 in the same cycle, giving full throughput of 1 beat/cycle.
  - Latency: 1 cycle from input acceptance (or generation) to ext_data_o_valid.
  - ext_data_o_valid/bits are held stable while ready=0.
- ext_data_i_ready: 1 only in RUN, mode REPLACE/PASS, and when the output register can accept. It is never high in IDLE or DRAIN, so no beat beyond N is consumed.
- Counter width: 32 bits. N=0xFFFFFFFF must complete without wrap issues.

Optional Feature:
- Macro MEMSET_INCR_EN.
- Defined:
  - In FILL/REPLACE, the per-element pattern is a running value that starts at csr0 and adds csr3 after every emitted beat.
  - Addition is modulo the element size: the sum is truncated to 8/16/32 bits, then replicated.
- Undefined:
  - The pattern is constant; csr3 is ignored and no adder or running register is instantiated.

Decomposition:
- Package memset_stream_pkg holds:
  - state_e enum (IDLE, RUN, DRAIN);
  - elem_size_e and mode_e enums;
  - CSR bit-field localparams;
  - function replicate_pattern(value, elem_size).
- One sub-module, memset_out_reg: the one-entry valid/ready pipeline register, parametrised by dataWidth.

Test Plan:
- FILL, 8b, csr0=0xA5, N=4, o_ready=1 -> 4 beats of all-0xA5 on consecutive cycles; i_ready stays 0; busy falls 1 cycle after the 4th handshake.
- REPLACE, 16b, csr0=0x1234, N=3, input valid with random stalls -> exactly 3 input beats consumed; outputs all 0x1234 replicated; the 4th input beat is left unconsumed (i_ready=0).
- PASS, N=5, output ready toggling 1/0 each cycle -> 5 input beats forwarded unchanged, in order; bits stable while ready=0; no beat loss or duplication.
- Edge cases:
  - start with N=0 -> busy never asserts, no output.
  - second start while busy -> ignored; beat count unchanged.
- Assert rst_n low after 2 of 8 beats -> valid/busy drop asynchronously; no further output after release.
- MEMSET_INCR_EN, 8b, csr0=0xFE, csr3=1, N=3 -> beats filled with 0xFE, 0xFF, 0x00 (8-bit wrap).
